// File: rtl/vbuffer_fetch_ctrl.sv
// Ping-pong fill scheduler for the pixel line buffer: fetches one scan line into the free half and steps the read pointer.
// Define VBUF_FETCH_UNDERRUN_EN to add the sticky Underrun flag output.
module vbuffer_fetch_ctrl #(
    parameter int AWIDTH      = 3,
    parameter int BPP         = 6,
    parameter int MAWIDTH     = 16,
    parameter int LINE_PIXELS = 640
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               FrameStart,
    input  logic               LineStart,
    input  logic               Active,
    input  logic               PixelEn,
    output logic               MemReq,
    output logic [MAWIDTH-1:0] MemAddr,
    input  logic               MemAck,
    input  logic [BPP-1:0]     MemData,
    output logic               BufWrite,
    output logic [AWIDTH-1:0]  BufWriteAddress,
    output logic [BPP-1:0]     BufData,
    output logic [AWIDTH-1:0]  BufReadAddress,
    output logic               BufBlank
`ifdef VBUF_FETCH_UNDERRUN_EN
    ,
    output logic               Underrun
`endif
);

    // state | meaning
    // IDLE  | no request outstanding; waits for pixels left to fetch and a free fill half
    // REQ   | MemReq high at MemAddr; each ack writes one pixel into the fill half
    // DRAIN | request abandoned by LineStart; waits for its ack and discards the data

    localparam int HALF   = 2 ** (AWIDTH - 1);
    localparam int RWIDTH = $clog2(LINE_PIXELS + 1);
    localparam int WWIDTH = AWIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [MAWIDTH-1:0]  mem_addr;
    logic [MAWIDTH-1:0]  line_base;
    logic [MAWIDTH-1:0]  line_base_sel;
    logic [1:0]          valid, valid_nxt;
    logic [AWIDTH-1:0]   read_ptr;
    logic                fill_half;
    logic [WWIDTH-1:0]   word_cnt;
    logic [RWIDTH-1:0]   remaining;
    logic [RWIDTH-1:0]   read_left;
    logic                ack_fill;
    logic                last_word;
    logic                rd_half;
    logic                rd_avail;
    logic                consume;
    logic                half_end;

    assign ack_fill      = (state == S_REQ) && MemAck && !LineStart;
    assign last_word     = (word_cnt == WWIDTH'(HALF - 1)) || (remaining == RWIDTH'(1));
    assign rd_half       = read_ptr[AWIDTH-1];
    // read_left stops the display at the line end, so slots past a partial last half blank
    assign rd_avail      = valid[rd_half] && (read_left != '0);
    assign consume       = PixelEn && Active && rd_avail;
    assign half_end      = &read_ptr[AWIDTH-2:0];
    assign line_base_sel = FrameStart ? '0 : line_base;

    assign MemReq          = (state != S_IDLE);
    assign MemAddr         = mem_addr;
    assign BufWrite        = ack_fill;
    assign BufWriteAddress = {fill_half, word_cnt};
    assign BufData         = MemData;
    assign BufReadAddress  = read_ptr;
    assign BufBlank        = !Active || !rd_avail;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if ((remaining != '0) && !valid[fill_half]) state_nxt = S_REQ;
            S_REQ:   if (MemAck && last_word) state_nxt = S_IDLE;
            S_DRAIN: if (MemAck) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // an unacked request cannot be withdrawn, so a new line parks it in DRAIN
        if (LineStart) begin
            state_nxt = ((state != S_IDLE) && !MemAck) ? S_DRAIN : S_IDLE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        valid_nxt = valid;
        if (ack_fill && last_word) valid_nxt[fill_half] = 1'b1;
        if (consume && half_end)   valid_nxt[rd_half]   = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem_addr  <= '0;
            line_base <= '0;
            valid     <= 2'b00;
            read_ptr  <= '0;
            fill_half <= 1'b0;
            word_cnt  <= '0;
            remaining <= '0;
            read_left <= '0;
        end else if (LineStart) begin
            mem_addr  <= line_base_sel;
            line_base <= line_base_sel + MAWIDTH'(LINE_PIXELS);
            valid     <= 2'b00;
            read_ptr  <= '0;
            fill_half <= 1'b0;
            word_cnt  <= '0;
            remaining <= RWIDTH'(LINE_PIXELS);
            read_left <= RWIDTH'(LINE_PIXELS);
        end else begin
            if (FrameStart) line_base <= '0;
            valid <= valid_nxt;
            if (ack_fill) begin
                mem_addr  <= mem_addr + MAWIDTH'(1);
                remaining <= remaining - RWIDTH'(1);
                if (last_word) begin
                    word_cnt  <= '0;
                    fill_half <= !fill_half;
                end else begin
                    word_cnt  <= word_cnt + WWIDTH'(1);
                end
            end
            if (consume) begin
                read_ptr  <= read_ptr + AWIDTH'(1);
                read_left <= read_left - RWIDTH'(1);
            end
        end
    end

`ifdef VBUF_FETCH_UNDERRUN_EN
    logic underrun_cond;

    assign underrun_cond = PixelEn && Active && !rd_avail &&
                           ((remaining != '0) || (state != S_IDLE));

    always_ff @(posedge Clk) begin
        if (Reset || LineStart)  Underrun <= 1'b0;
        else if (underrun_cond)  Underrun <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_vbuffer_fetch_ctrl.sv
// Self-checking bench for vbuffer_fetch_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a pixel-count model of the line fetch and display.
module tb_vbuffer_fetch_ctrl;

    localparam int AW    = 3;
    localparam int BPP   = 6;
    localparam int MAW   = 16;
    localparam int LP    = 10;
    localparam int HALF  = 2 ** (AW - 1);
    localparam int DEPTH = 2 ** AW;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic           FrameStart = 1'b0;
    logic           LineStart = 1'b0;
    logic           Active = 1'b0;
    logic           PixelEn = 1'b0;
    logic           MemAck = 1'b0;
    logic [BPP-1:0] MemData = '0;
    logic           MemReq;
    logic [MAW-1:0] MemAddr;
    logic           BufWrite;
    logic [AW-1:0]  BufWriteAddress;
    logic [BPP-1:0] BufData;
    logic [AW-1:0]  BufReadAddress;
    logic           BufBlank;
`ifdef VBUF_FETCH_UNDERRUN_EN
    logic           Underrun;
`endif

    vbuffer_fetch_ctrl #(
        .AWIDTH(AW), .BPP(BPP), .MAWIDTH(MAW), .LINE_PIXELS(LP)
    ) dut (
        .Clk(Clk), .Reset(Reset), .FrameStart(FrameStart), .LineStart(LineStart),
        .Active(Active), .PixelEn(PixelEn), .MemReq(MemReq), .MemAddr(MemAddr),
        .MemAck(MemAck), .MemData(MemData), .BufWrite(BufWrite),
        .BufWriteAddress(BufWriteAddress), .BufData(BufData),
        .BufReadAddress(BufReadAddress), .BufBlank(BufBlank)
`ifdef VBUF_FETCH_UNDERRUN_EN
        , .Underrun(Underrun)
`endif
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int n_wr = 0;
    int n_cons = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a line is LP pixels in groups of HALF; pixel p lives at address p mod DEPTH.
    int          m_len, m_f, m_c, m_done;
    bit          m_req, m_drain, m_under;
    logic [MAW-1:0] m_addr, m_base;

    initial begin
        m_len = 0; m_f = 0; m_c = 0; m_done = 0;
        m_req = 0; m_drain = 0; m_under = 0;
        m_addr = '0; m_base = '0;
    end

    function automatic bit readable();
        return (m_c < m_len) && (m_c < m_done);
    endfunction

    // the next group may be fetched once the group two places earlier is fully displayed
    function automatic bit can_fetch();
        int g;
        if (m_f >= m_len) return 1'b0;
        g = m_f / HALF;
        if (g < 2) return 1'b1;
        return m_c >= HALF * (g - 1);
    endfunction

    always @(posedge Clk) begin : model
        bit rd, att, free, ack;
        logic [MAW-1:0] nb;
        rd   = readable();
        att  = PixelEn && Active;
        ack  = MemAck;
        free = !m_req && !m_drain && can_fetch();
        if (Reset) begin
            m_len = 0; m_f = 0; m_c = 0; m_done = 0;
            m_req = 0; m_drain = 0; m_under = 0;
            m_addr = '0; m_base = '0;
        end else if (LineStart) begin
            nb      = FrameStart ? '0 : m_base;
            m_addr  = nb;
            m_base  = nb + MAW'(LP);
            m_drain = (m_req || m_drain) && !ack;
            m_req   = 0;
            m_len = LP; m_f = 0; m_c = 0; m_done = 0;
            m_under = 0;
        end else begin
            if (FrameStart) m_base = '0;
            if (att && !rd && ((m_f < m_len) || m_req || m_drain)) m_under = 1;
            if (m_drain) begin
                if (ack) m_drain = 0;
            end else if (m_req) begin
                if (ack) begin
                    m_f++;
                    m_addr = m_addr + MAW'(1);
                    if ((m_f % HALF == 0) || (m_f == m_len)) begin
                        m_req  = 0;
                        m_done = m_f;
                    end
                end
            end else if (free) begin
                m_req = 1;
            end
            if (att && rd) m_c++;
        end
    end

    always @(negedge Clk) begin : compare
        bit exp_wr;
        if (chk_en) begin
            exp_wr = m_req && MemAck && !LineStart;
            chk("MemReq", 32'(MemReq), 32'(m_req || m_drain));
            chk("MemAddr", 32'(MemAddr), 32'(m_addr));
            chk("BufWrite", 32'(BufWrite), 32'(exp_wr));
            if (exp_wr) begin
                chk("BufWriteAddress", 32'(BufWriteAddress), 32'(m_f % DEPTH));
                chk("BufData", 32'(BufData), 32'(MemData));
            end
            chk("BufReadAddress", 32'(BufReadAddress), 32'(m_c % DEPTH));
            chk("BufBlank", 32'(BufBlank), 32'(!Active || !readable()));
`ifdef VBUF_FETCH_UNDERRUN_EN
            chk("Underrun", 32'(Underrun), 32'(m_under));
`endif
            if (BufWrite) n_wr++;
            if (Active && PixelEn && !BufBlank) n_cons++;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
        MemData = BPP'($urandom);
    endtask

    task automatic wait_req(input string nm, input int lim);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge Clk);
            if (MemReq) seen = 1'b1;
            else step();
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    initial begin
        int mode, len, act_pre;
        Reset = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        @(negedge Clk);
        chk("rst_memreq", 32'(MemReq), 32'd0);
        chk("rst_memaddr", 32'(MemAddr), 32'd0);
        chk("rst_rdaddr", 32'(BufReadAddress), 32'd0);
        chk("rst_blank", 32'(BufBlank), 32'd1);
        step();
        Reset = 1'b0;

        // prefill both halves with acks always high
        FrameStart = 1'b1; LineStart = 1'b1; MemAck = 1'b1; Active = 1'b0;
        step();
        FrameStart = 1'b0; LineStart = 1'b0; n_wr = 0;
        repeat (20) step();
        @(negedge Clk);
        chk("prefill_writes", 32'(n_wr), 32'd8);
        chk("prefill_memreq", 32'(MemReq), 32'd0);
        chk("prefill_memaddr", 32'(MemAddr), 32'd8);

        // display the whole line, refilling half 0 with the 2-pixel tail
        step();
        n_cons = 0; Active = 1'b1; PixelEn = 1'b1;
        repeat (40) step();
        @(negedge Clk);
        chk("line_consumed", 32'(n_cons), 32'd10);
        chk("line_end_blank", 32'(BufBlank), 32'd1);
        chk("line_end_rdaddr", 32'(BufReadAddress), 32'd2);
        chk("line_end_memreq", 32'(MemReq), 32'd0);

        // LineStart while a request waits for its ack
        step();
        Active = 1'b0; PixelEn = 1'b0; MemAck = 1'b0; LineStart = 1'b1;
        step();
        LineStart = 1'b0;
        wait_req("req_line2_timeout", 20);
        chk("line2_addr", 32'(MemAddr), 32'd10);
        repeat (3) step();
        LineStart = 1'b1;
        step();
        LineStart = 1'b0;
        @(negedge Clk);
        chk("drain_hold", 32'(MemReq), 32'd1);
        chk("drain_newaddr", 32'(MemAddr), 32'd20);
        step();
        MemAck = 1'b1;
        @(negedge Clk);
        chk("drain_discard", 32'(BufWrite), 32'd0);
        step();
        MemAck = 1'b0;
        wait_req("req_after_drain_timeout", 20);
        chk("after_drain_addr", 32'(MemAddr), 32'd20);

        // FrameStart rewinds the line base
        step();
        FrameStart = 1'b1; LineStart = 1'b1;
        step();
        FrameStart = 1'b0; LineStart = 1'b0;
        @(negedge Clk);
        chk("frame_base", 32'(MemAddr), 32'd0);
        step();
        LineStart = 1'b1;
        step();
        LineStart = 1'b0;
        @(negedge Clk);
        chk("frame_line1", 32'(MemAddr), 32'd10);
        step();
        LineStart = 1'b1;
        step();
        LineStart = 1'b0;
        @(negedge Clk);
        chk("frame_line2", 32'(MemAddr), 32'd20);

        // randomized lines with varied ack patterns
        for (int blk = 0; blk < 60; blk++) begin
            step();
            mode    = int'($urandom_range(0, 2));
            len     = int'($urandom_range(25, 70));
            act_pre = int'($urandom_range(0, 12));
            Reset   = 1'b0;
            FrameStart = ($urandom_range(0, 3) == 0);
            LineStart  = 1'b1;
            step();
            LineStart = 1'b0;
            for (int c = 0; c < len; c++) begin
                if (mode == 0)      MemAck = ($urandom_range(0, 1) == 1);
                else if (mode == 1) MemAck = (c % 4 == 0);
                else                MemAck = 1'b1;
                Active     = (c >= act_pre) && ($urandom_range(0, 9) != 0);
                PixelEn    = ($urandom_range(0, 3) != 0);
                FrameStart = ($urandom_range(0, 49) == 0);
                Reset      = ($urandom_range(0, 399) == 0);
                step();
            end
        end
        Reset = 1'b0; FrameStart = 1'b0; Active = 1'b0; PixelEn = 1'b0;

        // reset while a request is outstanding
        MemAck = 1'b0; LineStart = 1'b1;
        step();
        LineStart = 1'b0;
        wait_req("req_before_reset_timeout", 20);
        Reset = 1'b1;
        step();
        @(negedge Clk);
        chk("reset_drops_req", 32'(MemReq), 32'd0);
        chk("reset_memaddr", 32'(MemAddr), 32'd0);
        step();
        Reset = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
